alu_result_buffer: RTL

//  Consumer-side capture stage for the combinational ALU (top). Accepts each issued

---
 rtl/alu_result_buffer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alu_result_buffer.sv
// alu_result_buffer
//    Capture stage behind the combinational ALU. It accepts each result with its
//    opcode tag and flags on a valid/ready handshake and stores them in a small
//    FIFO. Entries are presented to the downstream reader in arrival order.
//    Results that arrive while the buffer is full are counted in drop_cnt, which
//    saturates at 255.
//
//    Ports
//       clk, rst                   clock and asynchronous active-high reset
//       in_valid / in_ready        upstream handshake (in_ready = not full)
//       opcode, final_sum, cout,   ALU result, tag and flags of the issued op
//       negative_flag, overflow_flag, zero_flag
//       out_valid / out_ready      downstream handshake (out_valid = not empty)
//       out_opcode, out_sum,       head entry; all zero while out_valid = 0
//       out_flags                  flags are {cout, negative, overflow, zero}
//       count                      number of entries held
//       drop_cnt                   saturating count of refused results
//       clr_sticky, sticky_flags   only when STICKY_FLAGS_EN is defined
//
//    Build option
//       STICKY_FLAGS_EN  adds sticky_flags, the OR of the flags of every accepted
//                        result since reset or the last clr_sticky.

module alu_result_buffer #(
   parameter int WIDTH  = 32,
   parameter int OP_LEN = 5,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [OP_LEN-1:0]          opcode,
   input  logic [WIDTH-1:0]           final_sum,
   input  logic                       cout,
   input  logic                       negative_flag,
   input  logic                       overflow_flag,
   input  logic                       zero_flag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OP_LEN-1:0]          out_opcode,
   output logic [WIDTH-1:0]           out_sum,
   output logic [3:0]                 out_flags,
   output logic [$clog2(DEPTH):0]     count,
   output logic [7:0]                 drop_cnt
`ifdef STICKY_FLAGS_EN
   ,
   input  logic                       clr_sticky,
   output logic [3:0]                 sticky_flags
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = OP_LEN + WIDTH + 4;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [7:0]    r_drop_cnt;

   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [3:0]    w_in_flags;
   logic [EW-1:0] w_head;

   // Full/empty come only from the registered count, so neither handshake
   // output has a combinational path from in_valid or out_ready.
   assign w_full     = (r_count == FULL_CNT);
   assign w_empty    = (r_count == '0);
   assign in_ready   = ~w_full;
   assign out_valid  = ~w_empty;
   assign w_push     = in_valid & ~w_full;
   assign w_pop      = out_ready & ~w_empty;
   assign w_in_flags = {cout, negative_flag, overflow_flag, zero_flag};

   // Storage is not reset; stale contents are hidden by the output gating below.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {opcode, final_sum, w_in_flags};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_drop_cnt <= '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap by natural overflow.
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A result offered while full is lost even if a pop frees a slot this
         // cycle, because in_ready was already low.
         if (in_valid && w_full && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end
   end

`ifdef STICKY_FLAGS_EN
   logic [3:0] r_sticky;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sticky <= '0;
      end else if (w_push) begin
         // Clear and push together keep only the newly pushed flags.
         r_sticky <= (clr_sticky ? 4'b0000 : r_sticky) | w_in_flags;
      end else if (clr_sticky) begin
         r_sticky <= '0;
      end
   end

   assign sticky_flags = r_sticky;
`endif

   assign w_head     = r_mem[r_rd_ptr];
   assign out_flags  = out_valid ? w_head[3:0]               : '0;
   assign out_sum    = out_valid ? w_head[WIDTH+3:4]         : '0;
   assign out_opcode = out_valid ? w_head[EW-1:WIDTH+4]      : '0;
   assign count      = r_count;
   assign drop_cnt   = r_drop_cnt;

endmodule
